// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared constants and state/owner types for the framebuffer arbiter
package vga_fb_pkg;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
   typedef enum logic [1:0] {IDLE, FLUSH, FETCH, DONE} frame_state_t;
   typedef enum logic [1:0] {NONE, SCAN, CPU} owner_t;
endpackage

// File: rtl/vga_fb_arbiter_fifo.sv
// fb_pixel_fifo: show-ahead pixel FIFO; rdata is the head (0 when empty), flush wins over push/pop
// ports: pclk/reset (async active-low), flush, push+wdata, pop, rdata, level, empty, full
module fb_pixel_fifo #(
   parameter int DW = 24,
   parameter int DEPTH = 8
) (
   input  logic                   pclk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DW-1:0]          wdata,
   output logic [DW-1:0]          rdata,
   output logic [$clog2(DEPTH):0] level,
   output logic                   empty,
   output logic                   full
);
   localparam int PW = $clog2(DEPTH);
   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic push_ok, pop_ok;
   assign empty = level == '0;
   assign full = level == (PW + 1)'(DEPTH);
   assign push_ok = push && !full;
   assign pop_ok = pop && !empty;
   assign rdata = empty ? '0 : mem[rp];
   always_ff @(posedge pclk)
      if (push_ok && !flush) mem[wp] <= wdata;
   always_ff @(posedge pclk or negedge reset)
      if (!reset) begin
         wp <= '0;
         rp <= '0;
         level <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
         level <= '0;
      end else begin
         wp <= wp + PW'(push_ok);
         rp <= rp + PW'(pop_ok);
         level <= level + (PW + 1)'(push_ok) - (PW + 1)'(pop_ok);
      end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scanout prefetch and a CPU port
// ports: pclk/reset (async active-low); vsync, pix_pop -> pix_data, underflow (scanout side);
//        cpu_req/we/addr/wdata -> cpu_gnt, cpu_rvalid, cpu_rdata; mem_addr/en/we/wdata <- mem_rdata (RAM)
module vga_fb_arbiter #(
   parameter int H_ACTIVE = vga_fb_pkg::H_ACTIVE,
   parameter int V_ACTIVE = vga_fb_pkg::V_ACTIVE,
   parameter int AW = 19,
   parameter int DW = 24,
   parameter int FIFO_DEPTH = 8
) (
   input  logic          pclk,
   input  logic          reset,
   input  logic          vsync,
   input  logic          pix_pop,
   output logic [DW-1:0] pix_data,
   output logic          underflow,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_en,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   import vga_fb_pkg::*;
   localparam int FRAME = H_ACTIVE * V_ACTIVE;
   frame_state_t state, state_nx;
   owner_t owner, owner_nx;
   logic vsync_q, fall, scan_need, push, empty, full;
   logic [AW-1:0] fetch_addr;
   logic [$clog2(FIFO_DEPTH):0] level;
   assign fall = vsync_q && !vsync;
   // counts the read already in flight so the FIFO can never be over-requested
   assign scan_need = state == FETCH && (32'(level) + 32'(owner == SCAN)) < FIFO_DEPTH;
   // a scan word returning during FLUSH belongs to the previous frame
   assign push = owner == SCAN && state != FLUSH;
   assign cpu_gnt = reset && cpu_req && !scan_need;
   assign mem_en = scan_need || cpu_gnt;
   assign mem_we = cpu_gnt && cpu_we;
   assign mem_addr = scan_need ? fetch_addr : cpu_gnt ? cpu_addr : '0;
   assign mem_wdata = mem_we ? cpu_wdata : '0;
   assign cpu_rvalid = owner == CPU;
   assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
   always_comb begin
      state_nx = fall ? FLUSH :
                 state == FLUSH ? FETCH :
                 (state == FETCH && scan_need && fetch_addr == AW'(FRAME - 1)) ? DONE : state;
      owner_nx = scan_need ? SCAN : (cpu_gnt && !cpu_we) ? CPU : NONE;
   end
   always_ff @(posedge pclk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         owner <= NONE;
         vsync_q <= 1'b1;
         fetch_addr <= '0;
         underflow <= 1'b0;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
         vsync_q <= vsync;
         fetch_addr <= state == FLUSH ? '0 : scan_need ? fetch_addr + AW'(1) : fetch_addr;
         underflow <= state == FLUSH ? 1'b0 : underflow || (pix_pop && empty);
      end
   fb_pixel_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .pclk(pclk),
      .reset(reset),
      .flush(state == FLUSH),
      .push(push),
      .pop(pix_pop),
      .wdata(mem_rdata),
      .rdata(pix_data),
      .level(level),
      .empty(empty),
      .full(full)
   );
endmodule
